pc_loader_16: RTL and testbench

//  16-bit program counter built from four cascaded synchronous nibble-counter stages (163-style: enp/ent, ripple carry).

---
 rtl/pc_loader_16.sv | 94 +++++++++
 tb/tb_pc_loader_16.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_loader_16.sv
// 16-bit program counter from four cascaded nibble stages, with a two-byte jump-target stager
// that commits the staged target to pc in a single parallel load.
module pc_loader_16 #(
   parameter logic [15:0] RESET_PC        = 16'h0000,
   parameter bit          INC_WHILE_ARMED = 1'b1
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [7:0]  d,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic        jump,
   input  logic        cond,
   input  logic        inc,
   input  logic        cnt_en,
   output logic [15:0] pc,
   output logic [15:0] staged,
   output logic [1:0]  state,
   output logic [3:0]  nib_rco,
   output logic        rco,
   output logic        err
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StHalf = 2'd1, StFull = 2'd2} st_e;

   st_e         st_q, st_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] staged_q, staged_d;
   logic        err_q, err_d;
   logic        enp;
   logic        load;
   logic [3:0]  ent;

   // Carry of stage i looks at every pc bit up to and including that nibble.
   for (genvar g = 0; g < 4; g++) begin : g_rco
      assign nib_rco[g] = cnt_en & (&pc_q[4*g+3:0]);
   end

   assign ent = {nib_rco[2:0], cnt_en};
   assign enp = inc & (INC_WHILE_ARMED || (st_q == StEmpty));
   assign load = jump & cond & (st_q == StFull);

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = staged_q;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (enp && ent[i]) pc_d[4*i +: 4] = pc_q[4*i +: 4] + 4'd1;
         end
      end
   end

   always_comb begin
      staged_d = staged_q;
      st_d     = st_q;
      err_d    = err_q;
      if (we_lo) staged_d[7:0]  = d;
      if (we_hi) staged_d[15:8] = d;
      if (jump) begin
         // A jump always empties the stager; a same-cycle low write re-arms it halfway.
         st_d = we_lo ? StHalf : StEmpty;
         if (st_q != StFull) err_d = 1'b1;
      end else begin
         unique case (st_q)
            StEmpty: if (we_lo) st_d = StHalf;
            StHalf:  if (we_hi) st_d = StFull;
            StFull:  st_d = StFull;
            default: st_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pc_q     <= RESET_PC;
         staged_q <= 16'h0000;
         st_q     <= StEmpty;
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         staged_q <= staged_d;
         st_q     <= st_d;
         err_q    <= err_d;
      end
   end

   assign pc     = pc_q;
   assign staged = staged_q;
   assign state  = st_q;
   assign rco    = nib_rco[3];
   assign err    = err_q;

endmodule

// File: tb/tb_pc_loader_16.sv
// Directed self-checking bench for pc_loader_16: reset, counting/carry, staging, jumps, errors.
module tb_pc_loader_16;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [7:0]  d;
   logic        we_lo, we_hi, jump, cond, inc, cnt_en;
   logic [15:0] pc, staged;
   logic [1:0]  state;
   logic [3:0]  nib_rco;
   logic        rco, err;

   int n_total = 0;
   int n_pass  = 0;

   pc_loader_16 dut (
      .clk     (clk),
      .clr_n   (clr_n),
      .d       (d),
      .we_lo   (we_lo),
      .we_hi   (we_hi),
      .jump    (jump),
      .cond    (cond),
      .inc     (inc),
      .cnt_en  (cnt_en),
      .pc      (pc),
      .staged  (staged),
      .state   (state),
      .nib_rco (nib_rco),
      .rco     (rco),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d = 8'h00; we_lo = 0; we_hi = 0; jump = 0; cond = 0; inc = 0; cnt_en = 0;
   endtask

   // Stage a target and commit it with counting disabled.
   task automatic load_pc(input logic [15:0] t);
      idle();
      we_lo = 1; d = t[7:0];  tick();
      we_lo = 0; we_hi = 1; d = t[15:8]; tick();
      we_hi = 0; jump = 1; cond = 1; tick();
      idle();
   endtask

   initial begin
      idle();
      clr_n = 0;
      #12;
      check("reset_pc", pc, 16'h0000);
      check("reset_state", {14'd0, state}, 16'd0);
      check("reset_err", {15'd0, err}, 16'd0);
      clr_n = 1;

      // 1: async clear mid-count
      inc = 1; cnt_en = 1;
      tick(); tick(); tick();
      check("count3", pc, 16'h0003);
      #2 clr_n = 0;
      #1;
      check("async_clr_pc", pc, 16'h0000);
      check("async_clr_state", {14'd0, state}, 16'd0);
      check("async_clr_err", {15'd0, err}, 16'd0);
      clr_n = 1;
      idle();

      // we_hi alone leaves the stager empty but writes the byte
      we_hi = 1; d = 8'h5A; tick(); idle();
      check("hi_only_state", {14'd0, state}, 16'd0);
      check("hi_only_staged", staged, 16'h5A00);

      // 2: nibble carry chain
      load_pc(16'h00FE);
      check("load_00fe", pc, 16'h00FE);
      inc = 1; cnt_en = 1; tick();
      check("pc_00ff", pc, 16'h00FF);
      check("nib_rco_00ff", {12'd0, nib_rco}, 16'h0003);
      tick();
      check("pc_0100", pc, 16'h0100);
      check("nib_rco_0100", {12'd0, nib_rco}, 16'h0000);

      // 3: full carry and wrap
      load_pc(16'hFFFF);
      cnt_en = 1; inc = 0; #1;
      check("rco_ffff", {15'd0, rco}, 16'd1);
      tick();
      check("hold_ffff", pc, 16'hFFFF);
      inc = 1; tick();
      check("wrap_pc", pc, 16'h0000);
      check("wrap_rco", {15'd0, rco}, 16'd0);
      idle();

      // 4: load suppresses the increment
      we_lo = 1; d = 8'h34; tick();
      we_lo = 0; we_hi = 1; d = 8'h12; tick();
      we_hi = 0; jump = 1; cond = 1; inc = 1; cnt_en = 1; tick();
      idle();
      check("jump_1234", pc, 16'h1234);
      check("jump_state", {14'd0, state}, 16'd0);

      // 5: discarded jump, then jump from HALF
      load_pc(16'h0010);
      we_lo = 1; d = 8'h77; tick();
      we_lo = 0; we_hi = 1; d = 8'h66; tick();
      we_hi = 0;
      check("full_state", {14'd0, state}, 16'd2);
      jump = 1; cond = 0; inc = 1; cnt_en = 1; tick();
      idle();
      check("nocond_pc", pc, 16'h0011);
      check("nocond_state", {14'd0, state}, 16'd0);
      check("nocond_err", {15'd0, err}, 16'd0);
      we_lo = 1; d = 8'h01; tick();
      we_lo = 0;
      check("half_state", {14'd0, state}, 16'd1);
      jump = 1; cond = 1; tick();
      idle();
      check("half_jump_err", {15'd0, err}, 16'd1);
      check("half_jump_pc", pc, 16'h0011);
      check("half_jump_state", {14'd0, state}, 16'd0);
      tick(); tick();
      check("err_sticky", {15'd0, err}, 16'd1);
      #2 clr_n = 0;
      #1;
      check("err_cleared", {15'd0, err}, 16'd0);
      clr_n = 1;

      // 6: same-cycle jump and low-byte write
      we_lo = 1; d = 8'hCD; tick();
      we_lo = 0; we_hi = 1; d = 8'hAB; tick();
      we_hi = 0;
      check("staged_abcd", staged, 16'hABCD);
      jump = 1; cond = 1; we_lo = 1; d = 8'h99; tick();
      idle();
      check("same_cyc_pc", pc, 16'hABCD);
      check("same_cyc_staged", staged, 16'hAB99);
      check("same_cyc_state", {14'd0, state}, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
